// File: rtl/scr_stack_ctrl.sv
// scr_stack_ctrl
// Command-driven controller in front of a 256 x 10-bit scratch RAM. It owns
// the stack pointer and drives the RAM address, write data and write enable.
// Supported commands are PUSH/POP, direct LD/ST, SP_LOAD and a full-RAM CLEAR
// sweep. Stack depth (0..256) is tracked separately from SP, so that
// overflow and underflow are judged on depth alone.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active high
//   CMD_VALID  in   command strobe (ignored while BUSY)
//   CMD[2:0]   in   000 NOP, 001 PUSH, 010 POP, 011 SP_LOAD, 100 LD, 101 ST,
//                   110 CLEAR, 111 reserved (NOP)
//   DIN[9:0]   in   write data for PUSH/ST
//   ADDR[7:0]  in   LD/ST address, or the new SP for SP_LOAD
//   SCR_DATA   in   RAM read data (combinational from SCR_ADDR)
//   SCR_ADDR   out  RAM address
//   SCR_DIN    out  RAM write data
//   SCR_WE     out  RAM write enable
//   DOUT       out  registered POP/LD result
//   DOUT_VALID out  one-cycle pulse when DOUT updates
//   SP         out  stack pointer
//   BUSY       out  high during the CLEAR sweep
//   ERR        out  sticky flag set by a rejected PUSH (full) or POP (empty)
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | accepting commands, one per cycle
// ST_CLEAR | writing zero to addresses 0..255, commands dropped

module scr_stack_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CMD_VALID,
   input  logic [2:0] CMD,
   input  logic [9:0] DIN,
   input  logic [7:0] ADDR,
   input  logic [9:0] SCR_DATA,
   output logic [7:0] SCR_ADDR,
   output logic [9:0] SCR_DIN,
   output logic       SCR_WE,
   output logic [9:0] DOUT,
   output logic       DOUT_VALID,
   output logic [7:0] SP,
   output logic       BUSY,
   output logic       ERR
);

   localparam logic [2:0] CMD_PUSH    = 3'b001;
   localparam logic [2:0] CMD_POP     = 3'b010;
   localparam logic [2:0] CMD_SP_LOAD = 3'b011;
   localparam logic [2:0] CMD_LD      = 3'b100;
   localparam logic [2:0] CMD_ST      = 3'b101;
   localparam logic [2:0] CMD_CLEAR   = 3'b110;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t     state;
   logic [8:0] depth;
   logic [7:0] counter;
   logic       accept;
   logic       full;
   logic       empty;
   logic       we_raw;

   assign accept = CMD_VALID && (state == ST_IDLE);
   assign full   = (depth == 9'd256);
   assign empty  = (depth == 9'd0);

   // RAM port is combinational so PUSH/ST write on the accepting edge.
   always_comb begin
      SCR_ADDR = SP;
      SCR_DIN  = 10'd0;
      we_raw   = 1'b0;
      if (state == ST_CLEAR) begin
         SCR_ADDR = counter;
         we_raw   = 1'b1;
      end else if (accept) begin
         case (CMD)
            CMD_PUSH: begin
               SCR_ADDR = SP - 8'd1;
               SCR_DIN  = DIN;
               we_raw   = !full;
            end
            CMD_POP: SCR_ADDR = SP;
            CMD_LD:  SCR_ADDR = ADDR;
            CMD_ST: begin
               SCR_ADDR = ADDR;
               SCR_DIN  = DIN;
               we_raw   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Command inputs may toggle while reset is held; keep the RAM untouched.
   assign SCR_WE = we_raw && !RST;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         SP         <= 8'd0;
         depth      <= 9'd0;
         counter    <= 8'd0;
         DOUT       <= 10'd0;
         DOUT_VALID <= 1'b0;
         BUSY       <= 1'b0;
         ERR        <= 1'b0;
      end else begin
         DOUT_VALID <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  case (CMD)
                     CMD_PUSH: begin
                        if (full) begin
                           ERR <= 1'b1;
                        end else begin
                           SP    <= SP - 8'd1;
                           depth <= depth + 9'd1;
                        end
                     end
                     CMD_POP: begin
                        if (empty) begin
                           ERR <= 1'b1;
                        end else begin
                           DOUT       <= SCR_DATA;
                           DOUT_VALID <= 1'b1;
                           SP         <= SP + 8'd1;
                           depth      <= depth - 9'd1;
                        end
                     end
                     CMD_SP_LOAD: begin
                        SP    <= ADDR;
                        depth <= 9'd0;
                        ERR   <= 1'b0;
                     end
                     CMD_LD: begin
                        DOUT       <= SCR_DATA;
                        DOUT_VALID <= 1'b1;
                     end
                     CMD_CLEAR: begin
                        state   <= ST_CLEAR;
                        counter <= 8'd0;
                        BUSY    <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ST_CLEAR: begin
               counter <= counter + 8'd1;
               if (counter == 8'hFF) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
                  SP    <= 8'd0;
                  depth <= 9'd0;
                  ERR   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_scr_stack_ctrl.sv
module tb_scr_stack_ctrl;

   localparam logic [2:0] C_NOP  = 3'b000;
   localparam logic [2:0] C_PUSH = 3'b001;
   localparam logic [2:0] C_POP  = 3'b010;
   localparam logic [2:0] C_SPL  = 3'b011;
   localparam logic [2:0] C_LD   = 3'b100;
   localparam logic [2:0] C_ST   = 3'b101;
   localparam logic [2:0] C_CLR  = 3'b110;
   localparam logic [2:0] C_RSV  = 3'b111;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [9:0] din;
   logic [7:0] addr;
   logic [9:0] scr_data;
   logic [7:0] scr_addr;
   logic [9:0] scr_din;
   logic       scr_we;
   logic [9:0] dout;
   logic       dout_valid;
   logic [7:0] sp;
   logic       busy;
   logic       err;

   logic [9:0] mem [256];

   int checks = 0;
   int failures = 0;

   scr_stack_ctrl dut (
      .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD(cmd), .DIN(din),
      .ADDR(addr), .SCR_DATA(scr_data), .SCR_ADDR(scr_addr),
      .SCR_DIN(scr_din), .SCR_WE(scr_we), .DOUT(dout),
      .DOUT_VALID(dout_valid), .SP(sp), .BUSY(busy), .ERR(err)
   );

   always #5 clk = ~clk;

   // Scratch RAM: combinational read, synchronous write
   assign scr_data = mem[scr_addr];
   always @(posedge clk) if (scr_we) mem[scr_addr] <= scr_din;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive a command at the falling edge; combinational outputs settle after #1
   task automatic drive(input logic v, input logic [2:0] c,
                        input logic [9:0] d, input logic [7:0] a);
      @(negedge clk);
      cmd_valid = v; cmd = c; din = d; addr = a;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       v;
      logic [2:0] c;
      logic [9:0] d;
      logic [7:0] a;
      logic       e_we;
      logic [7:0] e_addr;
      logic [9:0] e_sdin;
      logic       e_dv;
      logic [9:0] e_dout;
      logic [7:0] e_sp;
      logic       e_err;
   } vec_t;

   vec_t vecs [14];

   initial begin
      int n;
      vecs[0]  = '{1'b1, C_POP,  10'h000, 8'h00, 1'b0, 8'h00, 10'h000, 1'b0, 10'h000, 8'h00, 1'b1};
      vecs[1]  = '{1'b1, C_SPL,  10'h123, 8'h80, 1'b0, 8'h00, 10'h000, 1'b0, 10'h000, 8'h80, 1'b0};
      vecs[2]  = '{1'b1, C_SPL,  10'h000, 8'h00, 1'b0, 8'h80, 10'h000, 1'b0, 10'h000, 8'h00, 1'b0};
      vecs[3]  = '{1'b1, C_PUSH, 10'h155, 8'h33, 1'b1, 8'hFF, 10'h155, 1'b0, 10'h000, 8'hFF, 1'b0};
      vecs[4]  = '{1'b1, C_PUSH, 10'h2AA, 8'h00, 1'b1, 8'hFE, 10'h2AA, 1'b0, 10'h000, 8'hFE, 1'b0};
      vecs[5]  = '{1'b1, C_POP,  10'h3FF, 8'h00, 1'b0, 8'hFE, 10'h000, 1'b1, 10'h2AA, 8'hFF, 1'b0};
      vecs[6]  = '{1'b1, C_POP,  10'h000, 8'h00, 1'b0, 8'hFF, 10'h000, 1'b1, 10'h155, 8'h00, 1'b0};
      vecs[7]  = '{1'b1, C_NOP,  10'h3FF, 8'h10, 1'b0, 8'h00, 10'h000, 1'b0, 10'h155, 8'h00, 1'b0};
      vecs[8]  = '{1'b1, C_ST,   10'h3FF, 8'h10, 1'b1, 8'h10, 10'h3FF, 1'b0, 10'h155, 8'h00, 1'b0};
      vecs[9]  = '{1'b1, C_LD,   10'h000, 8'h10, 1'b0, 8'h10, 10'h000, 1'b1, 10'h3FF, 8'h00, 1'b0};
      vecs[10] = '{1'b1, C_RSV,  10'h3FF, 8'h10, 1'b0, 8'h00, 10'h000, 1'b0, 10'h3FF, 8'h00, 1'b0};
      vecs[11] = '{1'b0, C_PUSH, 10'h3FF, 8'h10, 1'b0, 8'h00, 10'h000, 1'b0, 10'h3FF, 8'h00, 1'b0};
      vecs[12] = '{1'b1, C_POP,  10'h000, 8'h00, 1'b0, 8'h00, 10'h000, 1'b0, 10'h3FF, 8'h00, 1'b1};
      vecs[13] = '{1'b1, C_PUSH, 10'h001, 8'h00, 1'b1, 8'hFF, 10'h001, 1'b0, 10'h3FF, 8'hFF, 1'b1};

      for (int i = 0; i < 256; i++) mem[i] = 10'h000;

      // Reset, with a PUSH presented to show the write stays blocked
      rst = 1'b1; cmd_valid = 1'b1; cmd = C_PUSH; din = 10'h3FF; addr = 8'h00;
      #2;
      chk("rst_we", scr_we, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we_clk", scr_we, 0);
      chk("rst_sp", sp, 0);
      chk("rst_dout", dout, 0);
      chk("rst_dv", dout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].v, vecs[i].c, vecs[i].d, vecs[i].a);
         chk($sformatf("v%0d_we", i), scr_we, vecs[i].e_we);
         chk($sformatf("v%0d_saddr", i), scr_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_sdin", i), scr_din, vecs[i].e_sdin);
         tick();
         chk($sformatf("v%0d_dv", i), dout_valid, vecs[i].e_dv);
         chk($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
         chk($sformatf("v%0d_sp", i), sp, vecs[i].e_sp);
         chk($sformatf("v%0d_err", i), err, vecs[i].e_err);
      end

      // Fill the stack to 256, then overflow
      drive(1'b1, C_SPL, 10'h000, 8'h00);
      tick();
      chk("fill_start_err", err, 0);
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, C_PUSH, 10'(i), 8'h00);
         chk($sformatf("fill%0d_we", i), scr_we, 1);
         chk($sformatf("fill%0d_addr", i), scr_addr, 255 - i);
         tick();
      end
      chk("fill_sp", sp, 0);
      chk("fill_err", err, 0);
      drive(1'b1, C_PUSH, 10'h3FF, 8'h00);
      chk("ovf_we", scr_we, 0);
      tick();
      chk("ovf_err", err, 1);
      chk("ovf_sp", sp, 0);
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, C_POP, 10'h000, 8'h00);
         tick();
         chk($sformatf("drain%0d_dv", i), dout_valid, 1);
         chk($sformatf("drain%0d_dout", i), dout, 255 - i);
      end
      chk("drain_sp", sp, 0);
      drive(1'b0, C_NOP, 10'h000, 8'h00);
      tick();
      chk("drain_dv_drop", dout_valid, 0);
      chk("drain_err_sticky", err, 1);

      // CLEAR with RAM full of nonzero data (mem[a] = 255-a), PUSH held during BUSY
      drive(1'b1, C_CLR, 10'h000, 8'h00);
      chk("clr_accept_we", scr_we, 0);
      tick();
      chk("clr_busy_rise", busy, 1);
      n = 0;
      while (busy && n < 300) begin
         drive(1'b1, C_PUSH, 10'h3FF, 8'h00);
         if (n < 256) begin
            chk($sformatf("clr%0d_we", n), scr_we, 1);
            chk($sformatf("clr%0d_addr", n), scr_addr, n);
            chk($sformatf("clr%0d_din", n), scr_din, 0);
         end
         tick();
         n++;
      end
      chk("clr_busy_cycles", n, 256);
      chk("clr_sp", sp, 0);
      chk("clr_err", err, 0);
      drive(1'b1, C_LD, 10'h000, 8'h00);
      tick();
      chk("clr_ld00", dout, 0);
      drive(1'b1, C_LD, 10'h000, 8'h7F);
      tick();
      chk("clr_ld7f", dout, 0);
      drive(1'b1, C_LD, 10'h000, 8'hFF);
      tick();
      chk("clr_ldff", dout, 0);
      chk("clr_ld_dv", dout_valid, 1);
      chk("clr_sp_after", sp, 0);

      // Refill by ST, then reset during the sweep while address 100 is up
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, C_ST, {2'b10, 8'(i)}, 8'(i));
         tick();
      end
      drive(1'b1, C_CLR, 10'h000, 8'h00);
      tick();
      n = 0;
      while (busy && scr_addr != 8'd100 && n < 300) begin
         drive(1'b0, C_NOP, 10'h000, 8'h00);
         if (scr_addr != 8'd100) tick();
         n++;
      end
      chk("abort_addr", scr_addr, 100);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_we", scr_we, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, C_LD, 10'h000, 8'd99);
      tick();
      chk("abort_ld99", dout, 0);
      drive(1'b1, C_LD, 10'h000, 8'd100);
      tick();
      chk("abort_ld100", dout, 10'h264);
      drive(1'b1, C_LD, 10'h000, 8'd150);
      tick();
      chk("abort_ld150", dout, 10'h296);
      chk("abort_sp", sp, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scr_stack_ctrl.md
# scr_stack_ctrl

Command-driven controller sitting directly upstream of the 256 x 10-bit scratch RAM: it owns the stack pointer and drives the RAM's address, write-data and write-enable inputs. It executes PUSH/POP, direct LD/ST, SP load and a full-RAM CLEAR sweep. POP/LD results are registered from the RAM's combinational read port. Over/underflow is tracked against a 0..256 depth counter.

## Interface
- No parameters; widths fixed: 8-bit address, 10-bit data, 256 words.
- CLK  in  1  system clock, all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command strobe; accepted only when BUSY=0.
- CMD  in  3  000 NOP, 001 PUSH, 010 POP, 011 SP_LOAD, 100 LD, 101 ST, 110 CLEAR, 111 reserved (treated as NOP).
- DIN  in  10  data for PUSH/ST.
- ADDR  in  8  address for LD/ST; new SP value for SP_LOAD.
- SCR_DATA  in  10  RAM read data (combinational from SCR_ADDR).
- SCR_ADDR  out  8  RAM address.
- SCR_DIN  out  10  RAM write data.
- SCR_WE  out  1  RAM write enable.
- DOUT  out  10  registered POP/LD result.
- DOUT_VALID  out  1  one-cycle pulse when DOUT updated.
- SP  out  8  current stack pointer.
- BUSY  out  1  high while CLEAR sweep runs.
- ERR  out  1  sticky: rejected PUSH (full) or POP (empty).

## Operation
- States: IDLE, CLEAR. Reset -> IDLE.
- Accept = CMD_VALID & state==IDLE. Commands presented while BUSY are dropped; no queueing.
- PUSH: SCR_ADDR=SP-1 (mod 256), SCR_DIN=DIN, SCR_WE=1; at edge SP<=SP-1, depth<=depth+1. If depth==256: SCR_WE=0, SP/depth unchanged, ERR<=1.
- POP: SCR_ADDR=SP, SCR_WE=0; at edge DOUT<=SCR_DATA, DOUT_VALID<=1, SP<=SP+1, depth<=depth-1. If depth==0: no DOUT update, no DOUT_VALID, SP unchanged, ERR<=1.
- LD: SCR_ADDR=ADDR; at edge DOUT<=SCR_DATA, DOUT_VALID<=1. SP/depth unchanged.
- ST: SCR_ADDR=ADDR, SCR_DIN=DIN, SCR_WE=1. SP/depth unchanged.
- SP_LOAD: SP<=ADDR, depth<=0, ERR<=0. No RAM access.
- CLEAR: go to CLEAR with counter=0; each cycle SCR_ADDR=counter, SCR_DIN=0, SCR_WE=1; counter increments; after writing address 255 return to IDLE. Then SP<=0, depth<=0, ERR<=0.
- SP arithmetic wraps modulo 256 (SP=0 PUSH writes 255, SP=255 POP then SP=0). Overflow is judged by depth only.
- Idle/NOP/not-accepted: SCR_WE=0, SCR_DIN=0, SCR_ADDR=SP.
- ERR clears only on SP_LOAD, CLEAR completion or RST.

## Timing
- SCR_ADDR/SCR_DIN/SCR_WE are combinational from state, CMD, DIN, ADDR and SP, so PUSH/ST write at the same edge that accepts the command. There is no output register stage.
- PUSH, POP, LD, ST and SP_LOAD issue back-to-back, one per cycle. PUSH then POP on consecutive cycles returns the pushed value.
- POP/LD: DOUT and DOUT_VALID update at the accepting edge and are visible the cycle after. DOUT_VALID is high for exactly that one cycle. DOUT holds its value otherwise.
- CLEAR: BUSY rises the cycle after acceptance and stays high 256 cycles, one per address 0..255. BUSY=0 the cycle after the address-255 write.
- Reset values: SP=0, depth=0, DOUT=0, DOUT_VALID=0, BUSY=0, ERR=0, state IDLE, counter=0. SCR_WE=0 throughout reset.
- RST mid-CLEAR aborts immediately; RAM is left partially cleared and no further writes occur.

## Test plan
- Reset, then PUSH 0x155, 0x2AA -> writes at 255 and 254, SP=254. POP, POP -> DOUT 0x2AA then 0x155, SP=0, ERR=0.
- POP at reset (depth 0) -> SCR_WE=0, no DOUT_VALID, SP=0, ERR=1. SP_LOAD 0x80 -> SP=0x80, ERR=0.
- 256 PUSHes of i, then a 257th -> 257th rejected, ERR=1, SP=0. 256 POPs return 255..0 in order.
- ST 0x3FF at 0x10, then LD 0x10 next cycle -> DOUT=0x3FF with one-cycle DOUT_VALID. SP unchanged.
- CLEAR after filling RAM -> BUSY for 256 cycles, PUSH during BUSY is dropped. LD of 0x00, 0x7F and 0xFF afterwards returns 0, and SP=0.
- RST asserted in CLEAR cycle 100 -> BUSY=0 and SCR_WE=0 immediately. Address 99 reads 0 and address 150 keeps its old value.
